// File: rtl/readout_interpreter.sv
// ESN readout: streams state/weight words, MACs them, saturates and pulses ready.
// Build option READOUT_INTERPRETER_RELU_EN clamps negative results to zero.
module readout_interpreter #(
    parameter int N_NEURONS = 16,
    parameter int DATA_W    = 8,
    parameter int W_W       = 8,
    parameter int ACC_W     = 24,
    parameter int SHIFT     = 0,
    parameter int OUT_W     = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEn,
    output logic [ADDR_W-1:0] oAddr,
    input  logic [DATA_W-1:0] iState,
    input  logic [W_W-1:0]    iWeight,
    output logic [OUT_W-1:0]  oY,
    output logic              oIntRdy,
    output logic              oBusy
);

    localparam int PW  = DATA_W + W_W;
    localparam int EXT = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(N_NEURONS - 2);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(N_NEURONS - 1);

    localparam logic signed [EXT-1:0] Y_MAX =
        {{(EXT-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT-1:0] Y_MIN =
        {{(EXT-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_WAIT
    } state_t;

    state_t                   state_q;
    logic                     en_q;
    logic [ADDR_W-1:0]        addr_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic [OUT_W-1:0]         y_q;
    logic [OUT_W-1:0]         y_d;
    logic                     rdy_q;
    logic                     busy_q;

    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [EXT-1:0]    sh_ext;

    assign prod  = $signed(iState) * $signed(iWeight);
    assign acc_d = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};

    assign shifted = acc_q >>> SHIFT;
    assign sh_ext  = EXT'(shifted);

    always_comb begin
        y_d = sh_ext[OUT_W-1:0];
        if (sh_ext > Y_MAX) begin
            y_d = Y_MAX[OUT_W-1:0];
        end else if (sh_ext < Y_MIN) begin
            y_d = Y_MIN[OUT_W-1:0];
        end
`ifdef READOUT_INTERPRETER_RELU_EN
        if (y_d[OUT_W-1]) begin
            y_d = '0;
        end
`endif
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            addr_q  <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            en_q  <= iEn;
            rdy_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (iEn && !en_q) begin
                        state_q <= S_RUN;
                        acc_q   <= '0;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                // Memory data for the address issued last cycle arrives now.
                S_RUN: begin
                    acc_q  <= acc_d;
                    addr_q <= addr_q + 1'b1;
                    if (addr_q == PRE_LAST) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    acc_q   <= acc_d;
                    addr_q  <= LAST;
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    y_q     <= y_d;
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= iEn ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    if (!iEn) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign oAddr   = addr_q;
    assign oY      = y_q;
    assign oIntRdy = rdy_q;
    assign oBusy   = busy_q;

endmodule

// File: tb/tb_readout_interpreter.sv
// Bench for readout_interpreter: two N=4 instances (SHIFT 0 and 2) sharing
// stimulus, checked against an arithmetic reference of the readout rules.
module tb_readout_interpreter;

    logic clk = 1'b0;
    logic rst;
    logic en;

    logic [1:0]         a0, a1;
    logic [7:0]         sd0, sd1, wd0, wd1;
    logic signed [15:0] y0, y1;
    logic               rdy0, rdy1, busy0, busy1;

    logic signed [7:0] st [4];
    logic signed [7:0] wt [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign sd0 = st[a0];
    assign wd0 = wt[a0];
    assign sd1 = st[a1];
    assign wd1 = wt[a1];

    readout_interpreter #(
        .N_NEURONS(4), .DATA_W(8), .W_W(8), .ACC_W(24),
        .SHIFT(0), .OUT_W(16), .ADDR_W(2)
    ) dut0 (
        .iClk(clk), .iRst(rst), .iEn(en), .oAddr(a0),
        .iState(sd0), .iWeight(wd0), .oY(y0),
        .oIntRdy(rdy0), .oBusy(busy0)
    );

    readout_interpreter #(
        .N_NEURONS(4), .DATA_W(8), .W_W(8), .ACC_W(24),
        .SHIFT(2), .OUT_W(16), .ADDR_W(2)
    ) dut1 (
        .iClk(clk), .iRst(rst), .iEn(en), .oAddr(a1),
        .iState(sd1), .iWeight(wd1), .oY(y1),
        .oIntRdy(rdy1), .oBusy(busy1)
    );

    // Reference: dot product, arithmetic shift, clamp, optional ReLU.
    function automatic int model(input int sh);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            s += int'(st[i]) * int'(wt[i]);
        end
        s = s >>> sh;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef READOUT_INTERPRETER_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int flags();
        return int'({busy0, busy1, rdy0, rdy1});
    endfunction

    task automatic load(input int s0, input int s1, input int s2,
                        input int s3, input int w0, input int w1,
                        input int w2, input int w3);
        st[0] = 8'(s0); st[1] = 8'(s1); st[2] = 8'(s2); st[3] = 8'(s3);
        wt[0] = 8'(w0); wt[1] = 8'(w1); wt[2] = 8'(w2); wt[3] = 8'(w3);
    endtask

    task automatic load_rand();
        for (int i = 0; i < 4; i++) begin
            st[i] = 8'($urandom);
            wt[i] = 8'($urandom);
        end
    endtask

    // One full computation from the iEn rising edge to the ready pulse.
    task automatic do_run(input string tag, input bit drop_early);
        int e0;
        int e1;
        e0 = model(0);
        e1 = model(2);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_e0_flags"}, flags(), 4'b1100);
        check({tag, "_e0_addr"}, int'({a0, a1}), 0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check({tag, "_run_flags"}, flags(), 4'b1100);
            if (drop_early && k == 2) en = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, "_done_flags"}, flags(), 4'b0011);
        check({tag, "_y0"}, int'(y0), e0);
        check({tag, "_y1"}, int'(y1), e1);
        check({tag, "_addr_hold"}, int'({a0, a1}), 4'b1111);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_after_flags"}, flags(), 0);
        check({tag, "_y0_held"}, int'(y0), e0);
    endtask

    initial begin
        int cnt;
        int e0;
        rst = 1'b1;
        en  = 1'b0;
        load(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", flags(), 0);
        check("reset_y0", int'(y0), 0);
        check("reset_y1", int'(y1), 0);
        check("reset_addr", int'({a0, a1}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);

        load(1, 2, 3, 4, 1, 1, 1, 1);
        do_run("sum10", 1'b0);
        load(127, 127, 127, 127, 127, 127, 127, 127);
        do_run("satpos", 1'b0);
        load(-128, -128, -128, -128, 127, 127, 127, 127);
        do_run("satneg", 1'b0);
        load(4, 4, 4, 4, -1, -1, -1, -1);
        do_run("shift", 1'b0);
        load_rand();
        do_run("drop_early", 1'b1);

        // iEn held high for 20 cycles yields a single completion.
        load_rand();
        e0 = model(0);
        cnt = 0;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (rdy0) cnt++;
        end
        check("held_pulses", cnt, 1);
        check("held_y0", int'(y0), e0);
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(posedge clk);
        load_rand();
        do_run("restart", 1'b0);

        // Reset mid-run aborts without a ready pulse.
        load_rand();
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_flags", flags(), 0);
        check("abort_y", int'({y0, y1}), 0);
        check("abort_addr", int'({a0, a1}), 0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            if (rdy0 || rdy1 || busy0) cnt++;
        end
        check("abort_quiet", cnt, 0);
        do_run("post_abort", 1'b0);

        for (int r = 0; r < 8; r++) begin
            load_rand();
            do_run("rand", 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/readout_interpreter.md
# readout_interpreter

Integer ESN readout stage and the responder side of the handler's interpreter enable/ready handshake. Each time the enable rises, it streams the reservoir state vector and the matching output-weight vector from external synchronous memories and computes a signed dot product with a multiply-accumulate unit. The scaled, saturated result is registered on the output, and a one-cycle ready pulse returns control to the handler so the next reservoir step can start.

## Interface

- N_NEURONS, 16: reservoir size, i.e. number of MAC terms (≥2).
- DATA_W, 8: signed reservoir state width.
- W_W, 8: signed weight width.
- ACC_W, 24: accumulator width; must be ≥ DATA_W+W_W+clog2(N_NEURONS).
- SHIFT, 0: arithmetic right shift applied to the accumulator before output.
- OUT_W, 16: signed output width.
- ADDR_W, 4: address width; must satisfy 2^ADDR_W ≥ N_NEURONS.

Ports:

- iClk, input, 1: clock; all logic uses the rising edge.
- iRst, input, 1: reset, synchronous, active-high.
- iEn, input, 1: interpreter enable from the handler; a level signal, acted on at its rising edge only.
- oAddr, output, ADDR_W: shared read address for the state memory and the weight memory.
- iState, input, DATA_W: signed state word; valid one cycle after oAddr.
- iWeight, input, W_W: signed weight word; valid one cycle after oAddr.
- oY, output, OUT_W: signed readout result; held until the next completion.
- oIntRdy, output, 1: one-cycle completion pulse to the handler.
- oBusy, output, 1: high from the start of a computation until oIntRdy.

## Operation

**Reset** (iRst=1 at a clock edge):
- State goes to IDLE.
- oAddr=0, oY=0, oIntRdy=0, oBusy=0.
- Accumulator and enable-history register are cleared to 0.

**States:**
- IDLE → RUN when iEn=1 and the registered previous iEn=0.
  - Accumulator is cleared; oAddr=0; oBusy=1.
- RUN issues oAddr=0..N_NEURONS-1, one address per cycle.
  - From the second RUN cycle, acc += iState*iWeight, using a full-precision signed product sign-extended to ACC_W.
  - After address N_NEURONS-1 is issued → DRAIN.
- DRAIN accumulates the last product → OUT.
- OUT computes oY = sat_OUT_W(acc >>> SHIFT).
  - oIntRdy=1 for this cycle only; oBusy=0.
  - → WAIT if iEn=1, otherwise → IDLE.
- WAIT stays until iEn=0, then → IDLE.
  - The handler keeps iEn high for one cycle after ready; WAIT prevents that cycle from being taken as a new start.

**Arithmetic:**
- Accumulation is two's complement and wraps; the ACC_W rule above guarantees no overflow.
- Saturation clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].

**Boundaries:**
- iEn falling during RUN/DRAIN is ignored; the computation completes and oIntRdy still pulses.
- An iEn rising edge while busy is ignored.
- iRst during any state aborts immediately to reset values; no oIntRdy is issued.
- oAddr holds N_NEURONS-1 from DRAIN until the next start, then returns to 0.

## Timing

- Edge E0: iEn rising edge sampled; RUN entered with oAddr=0.
- Edge Ek (k=1..N_NEURONS): accumulates the term for address k-1.
- Latency: oY and oIntRdy update together at edge E(N_NEURONS+1), i.e. N_NEURONS+2 cycles counting E0.
- Minimum spacing between starts: N_NEURONS+3 cycles (OUT → IDLE → start).
- Memory contract: fixed one-cycle read latency; no stall or valid signal.

## Configuration

- Macro: READOUT_INTERPRETER_RELU_EN.
- Defined: the OUT result is max(0, sat_OUT_W(acc >>> SHIFT)), so negative results become 0.
- Undefined: the signed saturated result is output unchanged.
- Latency is identical in both builds.

## Test plan

- N_NEURONS=4, states [1,2,3,4], weights [1,1,1,1], SHIFT=0, iEn rising at E0 → oY=10 and a single oIntRdy pulse at E5; oBusy high from E0 through the cycle before E5.
- N_NEURONS=4, states all 127, weights all 127, OUT_W=16 → acc=64516, oY=32767.
- N_NEURONS=4, states all -128, weights all 127:
  - RELU_EN undefined → oY=-32768.
  - RELU_EN defined → oY=0.
- SHIFT=2, states [4,4,4,4], weights [-1,-1,-1,-1] → acc=-16, oY=-4.
- iEn held high for 20 cycles → exactly one oIntRdy pulse; dropping iEn then raising it again → a second computation starts.
- iRst asserted at E2 of a run → no oIntRdy; oY=0, oAddr=0, oBusy=0; a subsequent iEn edge completes normally with the correct result.
